// File: rtl/axi_operand_streamer.sv
// axi_operand_streamer
//   Transmit side of the MAC operand stream. A host fills a small register
//   file with operand pairs (a[i], b[i]); a start pulse then plays the first
//   len pairs out as a valid/ready/last stream that feeds the MAC directly.
//
// Ports
//   clock        rising-edge clock
//   rstn         asynchronous active-low reset
//   wr_en        buffer write strobe (honoured only while idle)
//   wr_addr      buffer write index
//   wr_a, wr_b   signed operands to store
//   len          vector length, sampled on an accepted start (clamped to DEPTH)
//   start        1-cycle pulse that begins streaming (ignored while busy)
//   busy         high from accepted start until the done pulse
//   done         1-cycle pulse after the final handshake
//   a, b         streamed operands (registered)
//   valid_o      stream valid
//   ready_i      downstream ready
//   last_o       marks the final pair of the vector
//   dbg_state_o  current FSM state (0 idle, 1 stream, 2 finish)
//
// Handshake: a pair moves on a rising edge where valid_o && ready_i. Once
// valid_o is raised, valid_o/a/b/last_o hold until that edge; valid_o is
// never a function of ready_i.
module axi_operand_streamer #(
    parameter int int_a  = 6,
    parameter int frac_a = 8,
    parameter int int_b  = 6,
    parameter int frac_b = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [int_a+frac_a-1:0]   wr_a,
    input  logic [int_b+frac_b-1:0]   wr_b,
    input  logic [AW:0]               len,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [int_a+frac_a-1:0]   a,
    output logic [int_b+frac_b-1:0]   b,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic [1:0]                dbg_state_o
);

    localparam int WA = int_a + frac_a;
    localparam int WB = int_b + frac_b;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [WA-1:0]   a_q, a_d;
    logic [WB-1:0]   b_q, b_d;

    logic [WA-1:0]   mem_a [DEPTH];
    logic [WB-1:0]   mem_b [DEPTH];

    logic            wr_fire;
    logic            xfer;
    logic [AW:0]     len_clamped;
    logic [AW-1:0]   idx_inc;

    assign wr_fire     = wr_en && (state_q == S_IDLE);
    assign xfer        = valid_q && ready_i;
    assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign idx_inc     = idx_q + 1'b1;

    // Operand buffer: no reset, writes only while idle so a running vector is frozen.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    // State register
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (len == '0) ? S_FINISH : S_STREAM;
            S_STREAM: if (xfer && last_q) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered stream/status outputs
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = len_clamped;
                    idx_d  = '0;
                    if (len != '0) begin
                        valid_d = 1'b1;
                        last_d  = (len_clamped == (AW+1)'(1));
                        // A write to entry 0 in the start cycle must be seen by the first beat.
                        if (wr_fire && (wr_addr == '0)) begin
                            a_d = wr_a;
                            b_d = wr_b;
                        end else begin
                            a_d = mem_a[0];
                            b_d = mem_b[0];
                        end
                    end
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_inc;
                        a_d    = mem_a[idx_inc];
                        b_d    = mem_b[idx_inc];
                        last_d = ({1'b0, idx_inc} == (cnt_q - 1'b1));
                    end
                end
            end
            S_FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign a           = a_q;
    assign b           = b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_operand_streamer.sv
module tb_axi_operand_streamer;

    localparam int W = 29;  // {a[13:0], b[13:0], last}

    logic        clock;
    logic        rstn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [13:0] wr_a;
    logic [13:0] wr_b;
    logic [4:0]  len;
    logic        start;
    logic        busy;
    logic        done;
    logic [13:0] a;
    logic [13:0] b;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic [1:0]  dbg_state_o;

    axi_operand_streamer dut (
        .clock       (clock),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .len         (len),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .a           (a),
        .b           (b),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state
    logic [13:0]  mem_a [16];
    logic [13:0]  mem_b [16];
    logic [W-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_beat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard and stall-stability checker, sampled on the falling edge
    always @(negedge clock) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_data", 32'({a, b, last_o}), 32'(prev_beat));
            end
            if (valid_o && ready_i) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {a, b, last_o});
                end else begin
                    chk("beat", 32'({a, b, last_o}), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_beat  = {a, b, last_o};
        end
    end

    // Expected beats for a vector of the requested length
    task automatic load_exp(input int n);
        int cnt;
        cnt = (n > 16) ? 16 : n;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({mem_a[i], mem_b[i], (i == cnt - 1) ? 1'b1 : 1'b0});
    endtask

    // Cycle (counted from the first valid cycle) in which done is seen,
    // given ready pattern bit j%16 in cycle j.
    function automatic int done_cycle(input int n, input logic [15:0] pat);
        int rem;
        int cnt;
        cnt = (n > 16) ? 16 : n;
        rem = cnt;
        if (cnt == 0) return 1;
        for (int j = 0; j < 1000; j++) begin
            if (pat[j % 16]) begin
                rem--;
                if (rem == 0) return j + 2;
            end
        end
        return -1;
    endfunction

    // Driver: single-cycle buffer write (called at posedge+1)
    task automatic write_entry(input int addr, input logic [13:0] va, input logic [13:0] vb);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_a    = va;
        wr_b    = vb;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        mem_a[addr] = va;
        mem_b[addr] = vb;
    endtask

    // Driver: run one vector to completion (called at posedge+1)
    task automatic run(input string tag, input int n, input logic [15:0] pat,
                       input int exp_beats, input int exp_done, input bit inject,
                       input bit wr0, input logic [13:0] wa, input logic [13:0] wb);
        int  j;
        int  dcyc;
        bit  found;
        if (wr0) begin
            mem_a[0] = wa;
            mem_b[0] = wb;
        end
        load_exp(n);
        beat_cnt = 0;
        start = 1'b1;
        len   = 5'(n);
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_a = wa; wr_b = wb;
        end
        @(posedge clock);
        #1;
        start   = 1'b0;
        wr_en   = 1'b0;
        ready_i = pat[0];
        j = 0; found = 0; dcyc = -1;
        while (!found && j < 300) begin
            @(negedge clock);
            if (j == 0) chk({tag, "_busy_first"}, 32'(busy), 32'd1);
            if (done) begin
                found = 1;
                dcyc  = j;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end else begin
                @(posedge clock);
                #1;
                j++;
                ready_i = pat[j % 16];
                if (inject && j == 1) begin
                    start = 1'b1; len = 5'd2;
                    wr_en = 1'b1; wr_addr = 4'd1; wr_a = 14'h1555; wr_b = 14'h2AAA;
                end else begin
                    start = 1'b0;
                    wr_en = 1'b0;
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end else begin
            chk({tag, "_done_cycle"}, 32'(dcyc), 32'(exp_done));
            @(negedge clock);
            chk({tag, "_done_width"}, 32'(done), 32'd0);
        end
        chk({tag, "_beats"}, 32'(beat_cnt), 32'(exp_beats));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [15:0] pat;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int nw;
        logic [15:0] pat;
        bit w0;

        vecs[0] = '{"full_len3",  3,  16'hFFFF, 3,  4};
        vecs[1] = '{"stall_len3", 3,  16'hFFE9, 3,  7};
        vecs[2] = '{"len0",       0,  16'hFFFF, 0,  1};
        vecs[3] = '{"len20",      20, 16'hFFFF, 16, 17};
        vecs[4] = '{"len1",       1,  16'hFFFF, 1,  2};
        vecs[5] = '{"len16",      16, 16'hFFFF, 16, 17};

        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        len = '0; start = 1'b0; ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_last",  32'(last_o),  32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_a",     32'(a),       32'd0);
        chk("rst_b",     32'(b),       32'd0);
        @(posedge clock);
        #1;
        rstn = 1'b1;
        @(posedge clock);
        #1;

        // Fill buffer, then the known Q6.8 vector in entries 0..2
        for (int i = 0; i < 16; i++)
            write_entry(i, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
        write_entry(0, 14'h0100, 14'h0080);
        write_entry(1, 14'h0200, 14'h0040);
        write_entry(2, 14'h3F80, 14'h0400);

        // Table-driven vectors
        for (int v = 0; v < 6; v++)
            run(vecs[v].name, vecs[v].n, vecs[v].pat, vecs[v].exp_beats, vecs[v].exp_done, 0, 0, '0, '0);

        // Start and write mid-stream are ignored; next run is clean and sees the same buffer
        run("midstream", 5, 16'hFFFF, 5, 6, 1, 0, '0, '0);
        run("after_mid", 5, 16'hFFFF, 5, 6, 0, 0, '0, '0);

        // Write to entry 0 in the start cycle reaches the first beat
        run("wr0_start", 3, 16'hFFFF, 3, 4, 0, 1, 14'h02A5, 14'h315A);

        // Reset after beat 2 of 5
        load_exp(5);
        beat_cnt = 0;
        start = 1'b1; len = 5'd5;
        @(posedge clock);
        #1;
        start = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_last",  32'(last_o),  32'd0);
        chk("midrst_busy",  32'(busy),    32'd0);
        chk("midrst_a",     32'(a),       32'd0);
        chk("midrst_beats", 32'(beat_cnt), 32'd2);
        exp_q.delete();
        repeat (2) begin
            @(negedge clock);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        @(posedge clock);
        #1;
        rstn = 1'b1;
        @(posedge clock);
        #1;
        run("after_rst", 5, 16'hFFFF, 5, 6, 0, 0, '0, '0);

        // Randomized runs against the model
        for (int r = 0; r < 10; r++) begin
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++)
                write_entry($urandom_range(0, 15), 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
            n   = $urandom_range(0, 20);
            pat = 16'($urandom_range(0, 65535)) | 16'h0001;
            w0  = 1'($urandom_range(0, 1));
            run("rand", n, pat, (n > 16) ? 16 : n, done_cycle(n, pat), 0, w0,
                14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
